// File: rtl/pot_scanner.sv
// pot_scanner: free-running scanner for six slide pots on an ADC128S 8-channel SPI A2D.
// Sends one 16-bit command frame per channel in a fixed round-robin order and captures
// the reply (which belongs to the channel addressed in the previous frame) into
// registered 12-bit pot settings.
//
// Parameters:
//   SCLK_DIV  system clocks per SCLK period (even, >= 4)
//   GAP       clocks SS_n stays high between frames (>= 2)
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI  SPI master outputs (SCLK idles high), all straight from flops
//   MISO              SPI data from the A2D
//   LP_pot .. volume  latest 12-bit result per pot
//   pots_vld          one-clock pulse when the volume pot (last in sweep) is written
//
// Optional feature: define POT_FILTER_EN to average each new sample with the held value.
module pot_scanner #(
    parameter int unsigned SCLK_DIV = 32,
    parameter int unsigned GAP      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [11:0] LP_pot,
    output logic [11:0] B1_pot,
    output logic [11:0] B2_pot,
    output logic [11:0] B3_pot,
    output logic [11:0] HP_pot,
    output logic [11:0] volume,
    output logic        pots_vld
);

    localparam logic [15:0] HalfEnd = 16'(SCLK_DIV / 2 - 1);
    localparam logic [15:0] GapEnd  = 16'(GAP - 1);

    typedef enum logic [1:0] {StGap, StFront, StShift, StBack} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic        ss_n_q, ss_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [2:0]  slot_q, slot_d;
    logic [2:0]  prev_slot_q, prev_slot_d;
    logic        first_q, first_d;
    logic        vld_q, vld_d;
    logic [11:0] pot_q [6];
    logic [11:0] pot_d [6];
    logic [15:0] cmd;
    logic        rx_unused;

    // Slot 5 (volume) lives on channel 7; the other slots map straight to their channel.
    function automatic logic [15:0] cmd_word(input logic [2:0] slot);
        logic [2:0] ch;
        ch = (slot == 3'd5) ? 3'd7 : slot;
        return {2'b00, ch, 11'h000};
    endfunction

    assign cmd       = cmd_word(slot_q);
    assign rx_unused = ^rx_q[15:12];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        bit_d       = bit_q;
        ss_n_d      = ss_n_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        slot_d      = slot_q;
        prev_slot_d = prev_slot_q;
        first_d     = first_q;
        vld_d       = 1'b0;
        pot_d       = pot_q;

        unique case (state_q)
            StGap: begin
                if (cnt_q == GapEnd) begin
                    state_d = StFront;
                    cnt_d   = '0;
                    ss_n_d  = 1'b0;
                    // MSB goes out with SS_n so it is settled before the first SCLK fall.
                    mosi_d  = cmd[15];
                    tx_d    = {cmd[14:0], 1'b0};
                    bit_d   = '0;
                end
            end
            StFront: begin
                if (cnt_q == HalfEnd) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                end
            end
            StShift: begin
                if (cnt_q == HalfEnd) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[14:0], MISO};
                        bit_d  = bit_q + 5'd1;
                    end else if (bit_q == 5'd16) begin
                        state_d = StBack;
                    end else begin
                        // Every fall after the first advances MOSI by one bit.
                        sclk_d = 1'b0;
                        mosi_d = tx_q[15];
                        tx_d   = {tx_q[14:0], 1'b0};
                    end
                end
            end
            StBack: begin
                if (cnt_q == HalfEnd) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    ss_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    // Reply belongs to the previous frame's slot; the first frame has none.
                    if (!first_q) begin
                        for (int i = 0; i < 6; i++) begin
                            if (prev_slot_q == 3'(i)) begin
`ifdef POT_FILTER_EN
                                pot_d[i] = 12'((13'(pot_q[i]) + 13'(rx_q[11:0]) + 13'd1) >> 1);
`else
                                pot_d[i] = rx_q[11:0];
`endif
                            end
                        end
                        vld_d = (prev_slot_q == 3'd5);
                    end
                    first_d     = 1'b0;
                    prev_slot_d = slot_q;
                    slot_d      = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
                end
            end
            default: state_d = StGap;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StGap;
            cnt_q       <= '0;
            bit_q       <= '0;
            ss_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            mosi_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            slot_q      <= '0;
            prev_slot_q <= '0;
            first_q     <= 1'b1;
            vld_q       <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                pot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            ss_n_q      <= ss_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            slot_q      <= slot_d;
            prev_slot_q <= prev_slot_d;
            first_q     <= first_d;
            vld_q       <= vld_d;
            for (int i = 0; i < 6; i++) begin
                pot_q[i] <= pot_d[i];
            end
        end
    end

    assign SS_n     = ss_n_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign pots_vld = vld_q;
    assign B1_pot   = pot_q[0];
    assign LP_pot   = pot_q[1];
    assign B3_pot   = pot_q[2];
    assign HP_pot   = pot_q[3];
    assign B2_pot   = pot_q[4];
    assign volume   = pot_q[5];

endmodule
